// File: rtl/ps2_kbd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_kbd_fifo : PS/2 keyboard receiver, E0/F0 prefix decoder and event FIFO
// Revision     : 1.0
// ---------------------------------------------------------------------------
module ps2_kbd_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [9:0]                    out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clear_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW:0]   DEPTH_L = FIFO_DEPTH[AW:0];
   localparam logic [AW:0]   LVL_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [TW-1:0] TO_MAX  = TIMEOUT_CYCLES[TW-1:0];
   localparam logic [TW-1:0] TO_ONE  = 1;
   localparam logic [3:0]    CNT_ONE = 4'd1;
   localparam logic [3:0]    CNT_LAST = 4'd10;

   // Encoding chosen so that the state bits are exactly {brk, ext}
   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_EXT     = 2'b01;
   localparam logic [1:0] S_BRK     = 2'b10;
   localparam logic [1:0] S_EXT_BRK = 2'b11;

   logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d, kdat_sync_q, kdat_sync_d;
   logic                   kclk_prev_q, kclk_prev_d;
   logic [10:0]            shift_q, shift_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [TW-1:0]          to_cnt_q, to_cnt_d;
   logic                   ferr_q, ferr_d;
   logic                   byte_vld_q, byte_vld_d;
   logic [7:0]             byte_q, byte_d;
   logic [1:0]             state_q, state_d;
   logic [9:0]             mem_q [FIFO_DEPTH];
   logic [9:0]             mem_d [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]            level_q, level_d;
   logic                   ovf_q, ovf_d;

   logic                   w_strobe, w_dat;
   logic [10:0]            w_frame;
   logic                   w_is_e0, w_is_f0, w_push, w_pop, w_accept;
   logic [9:0]             w_event;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kclk_sync_q <= '1;
         kdat_sync_q <= '1;
         kclk_prev_q <= 1'b1;
         shift_q     <= '0;
         cnt_q       <= '0;
         to_cnt_q    <= '0;
         ferr_q      <= 1'b0;
         byte_vld_q  <= 1'b0;
         byte_q      <= '0;
         state_q     <= S_IDLE;
         mem_q       <= '{default: 10'd0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         kclk_sync_q <= kclk_sync_d;
         kdat_sync_q <= kdat_sync_d;
         kclk_prev_q <= kclk_prev_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         to_cnt_q    <= to_cnt_d;
         ferr_q      <= ferr_d;
         byte_vld_q  <= byte_vld_d;
         byte_q      <= byte_d;
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      kclk_sync_d = {kclk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      kdat_sync_d = {kdat_sync_q[SYNC_STAGES-2:0], ps2_data};
      kclk_prev_d = kclk_sync_q[SYNC_STAGES-1];
      w_strobe    = !kclk_sync_q[SYNC_STAGES-1] && kclk_prev_q;
      w_dat       = kdat_sync_q[SYNC_STAGES-1];
   end

   // Bit capture, frame check and mid-frame timeout
   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      to_cnt_d   = to_cnt_q;
      ferr_d     = 1'b0;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      w_frame        = shift_q;
      w_frame[cnt_q] = w_dat;
      if (w_strobe) begin
         shift_d  = w_frame;
         to_cnt_d = '0;
         if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!w_frame[0] && w_frame[10] && (^w_frame[9:1])) begin
               byte_vld_d = 1'b1;
               byte_d     = w_frame[8:1];
            end else begin
               ferr_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (cnt_q != '0) begin
         if (to_cnt_q == TO_MAX) begin
            cnt_d    = '0;
            to_cnt_d = '0;
            ferr_d   = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   assign w_is_e0 = (byte_q == 8'hE0);
   assign w_is_f0 = (byte_q == 8'hF0);

   always_comb begin
      state_d = state_q;
      if (byte_vld_q) begin
         case (state_q)
            S_IDLE: begin
               if (w_is_e0)      state_d = S_EXT;
               else if (w_is_f0) state_d = S_BRK;
            end
            S_EXT: begin
               if (w_is_f0)       state_d = S_EXT_BRK;
               else if (!w_is_e0) state_d = S_IDLE;
            end
            S_BRK, S_EXT_BRK: begin
               if (!w_is_e0 && !w_is_f0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_push  = byte_vld_q && !w_is_e0 && !w_is_f0;
      w_event = {state_q, byte_q};
   end

   // FIFO: a pop in the same cycle frees the slot for a push at full
   always_comb begin
      w_pop    = (level_q != '0) && out_ready;
      w_accept = w_push && ((level_q != DEPTH_L) || w_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (w_accept) begin
         mem_d[wr_ptr_q] = w_event;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (w_accept && !w_pop) begin
         level_d = level_q + LVL_ONE;
      end else if (w_pop && !w_accept) begin
         level_d = level_q - LVL_ONE;
      end
      if (w_push && !w_accept) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_kbd_fifo : directed + randomized bench with a key-event reference model
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_ps2_kbd_fifo;
   localparam int DEPTH = 8;
   localparam int TO    = 1000;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       out_ready = 1'b0;
   logic       clear_ovf = 1'b0;
   logic [9:0] out_data;
   logic       out_valid;
   logic [3:0] level;
   logic       frame_err;
   logic       overflow;

   always #5 clk = ~clk;

   ps2_kbd_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .frame_err(frame_err), .overflow(overflow),
      .clear_ovf(clear_ovf)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [9:0] got[$];
   logic [9:0] exp_q[$];
   int         valid_hi = 0;
   int         ferr_cnt = 0;
   int         ferr_long = 0;
   bit         ferr_prev = 1'b0;
   int         mlevel = 0;
   bit         movf = 1'b0;
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   bit         sim_pop = 1'b0;
   bit         rnd_rdy = 1'b0;
   int         f0;

   // Observe handshakes and pulses on the falling edge, away from updates
   always @(negedge clk) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid) valid_hi++;
      if (frame_err) begin
         ferr_cnt++;
         if (ferr_prev) ferr_long++;
      end
      ferr_prev = frame_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic model_push(input logic [9:0] ev);
      if (mlevel < DEPTH || sim_pop) begin
         exp_q.push_back(ev);
         if (!sim_pop) mlevel++;
      end else begin
         movf = 1'b1;
      end
   endtask

   // F0 marks a break; E0 marks extended only before any F0; anything else is a key
   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) begin
         if (!m_brk) m_ext = 1'b1;
      end else begin
         model_push({m_brk, m_ext, b});
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         wait_clk(HALF);
         ps2_clk = 1'b0;
         if (sim_pop && i == 10) begin
            wait_clk(4);
            out_ready = 1'b1;
            wait_clk(1);
            out_ready = 1'b0;
            wait_clk(HALF - 5);
         end else begin
            wait_clk(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad, b, 1'b0};
      send_bits(f, 11);
      if (!bad) model_byte(b);
   endtask

   task automatic drain(input string tag);
      int n;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && (out_valid || got.size() < exp_q.size()); k++) wait_clk(1);
      check({tag, "_count"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) check(tag, got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
      mlevel = 0;
   endtask

   initial begin
      wait_clk(3);
      check("rst_data", out_data, 0);
      check("rst_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);
      reset_n = 1'b1;
      wait_clk(3);

      out_ready = 1'b1;
      valid_hi = 0;
      send_byte(8'h1C, 1'b0);
      drain("make_1c");
      check("make_valid_cycles", valid_hi, 1);
      check("make_level", level, 0);

      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      drain("break_1c");

      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h75, 1'b0);
      drain("ext_break_75");
      send_byte(8'h75, 1'b0);
      drain("plain_75");

      f0 = ferr_cnt;
      send_byte(8'h1C, 1'b1);
      check("parity_ferr", ferr_cnt - f0, 1);
      drain("parity_none");
      send_byte(8'h1C, 1'b0);
      drain("after_parity");

      out_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b0);
      check("full_level", level, mlevel);
      check("full_ovf", overflow, movf);
      clear_ovf = 1'b1;
      wait_clk(1);
      clear_ovf = 1'b0;
      movf = 1'b0;
      wait_clk(1);
      check("clear_ovf", overflow, movf);
      sim_pop = 1'b1;
      send_byte(8'h19, 1'b0);
      sim_pop = 1'b0;
      check("pushpop_level", level, mlevel);
      check("pushpop_ovf", overflow, movf);
      drain("full_order");

      for (int r = 0; r < 6; r++) begin
         rnd_rdy = 1'b1;
         for (int j = 0; j < 4; j++) begin
            int k;
            logic [7:0] b;
            k = $urandom_range(0, 9);
            b = (k < 2) ? 8'hE0 : (k < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_byte(b, $urandom_range(0, 9) == 0);
         end
         rnd_rdy = 1'b0;
         drain("random");
      end
      send_byte(8'h01, 1'b0);
      drain("resync");

      f0 = ferr_cnt;
      send_bits(11'h5A5, 5);
      wait_clk(TO + 50);
      check("timeout_ferr", ferr_cnt - f0, 1);
      check("timeout_valid", out_valid, 0);
      send_byte(8'h2D, 1'b0);
      drain("after_timeout");

      out_ready = 1'b0;
      send_byte(8'h33, 1'b0);
      send_bits(11'h0F0, 5);
      check("pre_reset_level", level, mlevel);
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_level", level, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_ovf", overflow, 0);
      exp_q.delete();
      got.delete();
      mlevel = 0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      wait_clk(2);
      reset_n = 1'b1;
      wait_clk(3);
      out_ready = 1'b1;
      send_byte(8'h4E, 1'b0);
      drain("after_reset");

      check("ferr_width", ferr_long, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
